sort_ctrl: RTL

SORT_CTRL -- requirements
Module: sort_ctrl

---
 rtl/sort_pkg.sv | 58 +++++
 rtl/sort_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/sort_pkg.sv
// sort_pkg: shared types and constants for the odd-even transposition sort
// controller. Holds the FSM state encoding, the element/phase-counter sizes,
// the registered control-output bundle and its per-state decode.
package sort_pkg;

  localparam int unsigned N_ELEM = 8;
  localparam int unsigned LC_W   = 3;
  localparam logic [LC_W-1:0] LAST_PHASE = 3'd7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    EVEN = 3'd2,
    ODD  = 3'd3,
    DONE = 3'd4
  } state_e;

  // Control outputs driven towards the datapath and the loop counter.
  typedef struct packed {
    logic load;
    logic cnt_clr;
    logic cnt_en;
    logic swap_even;
    logic swap_odd;
    logic busy;
    logic done;
  } ctrl_t;

  // Moore decode of the control bundle for a given state.
  function automatic ctrl_t ctrl_decode(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      LOAD: begin
        c.load    = 1'b1;
        c.cnt_clr = 1'b1;
        c.busy    = 1'b1;
      end
      EVEN: begin
        c.swap_even = 1'b1;
        c.cnt_en    = 1'b1;
        c.busy      = 1'b1;
      end
      ODD: begin
        c.swap_odd = 1'b1;
        c.cnt_en   = 1'b1;
        c.busy     = 1'b1;
      end
      DONE: begin
        c.done = 1'b1;
        c.busy = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sort_ctrl.sv
// sort_ctrl: sequences an 8-element odd-even transposition sort
// (LOAD, then 8 alternating EVEN/ODD phases, then a one-cycle DONE).
// The phase counter is external: cnt_clr clears it, cnt_en advances it, and
// lc reports the index of the phase executing in the current cycle.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          request a run (ignored while busy, never queued)
//   swapped        datapath saw a swap this phase (early-exit build only)
//   lc[2:0]        external phase count
//   cnt_en/cnt_clr loop counter controls
//   load           capture inputs into the datapath
//   swap_even/odd  compare/swap even or odd pairs
//   busy, done     run in progress, one-cycle completion pulse
// Build option: define SORT_EARLY_EXIT_EN to finish as soon as an EVEN/ODD
// pair completes with no swaps.
module sort_ctrl
  import sort_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            swapped,
  input  logic [LC_W-1:0] lc,
  output logic            cnt_en,
  output logic            cnt_clr,
  output logic            load,
  output logic            swap_even,
  output logic            swap_odd,
  output logic            busy,
  output logic            done
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

`ifdef SORT_EARLY_EXIT_EN
  logic swap_seen_q, swap_seen_d;
`else
  logic unused_swapped;
  assign unused_swapped = swapped;
`endif

  // Next-state logic; outputs are decoded from the next state so that the
  // registered outputs line up with the state they describe.
  always_comb begin
    state_d = state_q;
`ifdef SORT_EARLY_EXIT_EN
    swap_seen_d = swap_seen_q;
`endif
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: state_d = EVEN;
      EVEN: begin
        state_d = ODD;
`ifdef SORT_EARLY_EXIT_EN
        swap_seen_d = swapped;
`endif
      end
      ODD: begin
        if (lc == LAST_PHASE) begin
          state_d = DONE;
`ifdef SORT_EARLY_EXIT_EN
        end else if (!swap_seen_q && !swapped) begin
          // A clean EVEN/ODD pair means the array is already sorted.
          state_d = DONE;
`endif
        end else begin
          state_d = EVEN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ctrl_d = ctrl_decode(state_d);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
`ifdef SORT_EARLY_EXIT_EN
      swap_seen_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
`ifdef SORT_EARLY_EXIT_EN
      swap_seen_q <= swap_seen_d;
`endif
    end
  end

  assign load      = ctrl_q.load;
  assign cnt_clr   = ctrl_q.cnt_clr;
  assign cnt_en    = ctrl_q.cnt_en;
  assign swap_even = ctrl_q.swap_even;
  assign swap_odd  = ctrl_q.swap_odd;
  assign busy      = ctrl_q.busy;
  assign done      = ctrl_q.done;

endmodule
